// File: rtl/jamma_pkg.sv
// Shared JAMMA joystick definitions: player-vector bit indices and coin FSM states.
package jamma_pkg;

    localparam int UP        = 0;
    localparam int DOWN      = 1;
    localparam int LEFT      = 2;
    localparam int RIGHT     = 3;
    localparam int FIRE1     = 4;
    localparam int FIRE2     = 5;
    localparam int START     = 7;

    // 8 lines per player plus 2 coin switches
    localparam int NUM_LINES = 18;

    typedef enum logic [1:0] {
        COIN_IDLE,
        COIN_HOLD,
        COIN_WAIT_REL
    } coin_state_t;

endpackage

// File: rtl/jamma_debounce.sv
// Single-bit debouncer for an already synchronized line; counter is
// compiled in only when JAMMA_JOY_DEBOUNCE_EN is defined.
module jamma_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_sync,
    output logic o_clean
);

    logic r_clean;

    if (DEB_CYCLES < 1) begin : g_param_chk
        $error("jamma_debounce: DEB_CYCLES must be >= 1");
    end

`ifdef JAMMA_JOY_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] LIM = CW'(DEB_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    // Clean bit flips after DEB_CYCLES consecutive disagreeing samples
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt   <= '0;
            r_clean <= 1'b1;
        end else if (i_sync == r_clean) begin
            r_cnt   <= '0;
        end else if (r_cnt == LIM) begin
            r_cnt   <= '0;
            r_clean <= i_sync;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end
`else
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_clean <= 1'b1;
        end else begin
            r_clean <= i_sync;
        end
    end
`endif

    assign o_clean = r_clean;

endmodule

// File: rtl/jamma_joy_mux.sv
// JAMMA player/coin conditioner: sync, debounce (JAMMA_JOY_DEBOUNCE_EN),
// zero-latency player mux, coin pulse stretcher and JSELECT stall detector.
module jamma_joy_mux
    import jamma_pkg::*;
#(
    parameter int DEB_CYCLES   = 16,
    parameter int COIN_MIN     = 4096,
    parameter int STALL_CYCLES = 1024
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_p1_raw,
    input  logic [7:0] i_p2_raw,
    input  logic [1:0] i_coin_raw,
    input  logic       i_jselect,
    output logic [7:0] o_jjoy,
    output logic [1:0] o_jcoin,
    output logic       o_sel_stall
);

    localparam int CCW = $clog2(COIN_MIN + 1);
    localparam int SCW = $clog2(STALL_CYCLES + 1);

    logic [NUM_LINES-1:0] w_raw;
    logic [NUM_LINES-1:0] r_sync1;
    logic [NUM_LINES-1:0] r_sync2;
    logic [NUM_LINES-1:0] w_clean;
    logic [1:0]           r_coin_prev;
    logic                 r_js_prev;
    logic [SCW-1:0]       r_stall_cnt;

    assign w_raw = {i_coin_raw, i_p2_raw, i_p1_raw};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_deb
        jamma_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_sync  (r_sync2[g]),
            .o_clean (w_clean[g])
        );
    end

    // Select path stays combinational so the sampler can flip JSELECT every cycle
    assign o_jjoy = i_jselect ? w_clean[15:8] : w_clean[7:0];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_coin_prev <= 2'b11;
        end else begin
            r_coin_prev <= w_clean[17:16];
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_coin
        coin_state_t    r_st;
        coin_state_t    w_st_nxt;
        logic [CCW-1:0] r_cnt;
        logic [CCW-1:0] w_cnt_nxt;

        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                r_st  <= COIN_IDLE;
                r_cnt <= '0;
            end else begin
                r_st  <= w_st_nxt;
                r_cnt <= w_cnt_nxt;
            end
        end

        // Releasing at the end of HOLD skips WAIT_REL so the pulse is exactly COIN_MIN
        always_comb begin
            w_st_nxt  = r_st;
            w_cnt_nxt = r_cnt;
            unique case (r_st)
                COIN_IDLE: begin
                    if (r_coin_prev[g] && !w_clean[16+g]) begin
                        w_st_nxt  = COIN_HOLD;
                        w_cnt_nxt = CCW'(COIN_MIN - 1);
                    end
                end
                COIN_HOLD: begin
                    if (r_cnt == '0) begin
                        w_st_nxt = w_clean[16+g] ? COIN_IDLE : COIN_WAIT_REL;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                COIN_WAIT_REL: begin
                    if (w_clean[16+g]) begin
                        w_st_nxt = COIN_IDLE;
                    end
                end
                default: begin
                    w_st_nxt = COIN_IDLE;
                end
            endcase
        end

        assign o_jcoin[g] = (r_st == COIN_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_js_prev   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_js_prev <= i_jselect;
            if (i_jselect != r_js_prev) begin
                r_stall_cnt <= '0;
            end else if (r_stall_cnt != SCW'(STALL_CYCLES)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign o_sel_stall = (r_stall_cnt == SCW'(STALL_CYCLES));

endmodule

// File: doc/jamma_joy_mux.md
JAMMA_JOY_MUX -- requirements
Module: jamma_joy_mux

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 16, the consecutive stable cycles needed to accept a bit change.
REQ-002 SHALL have parameter COIN_MIN, default 4096, the minimum low time of a JCOIN pulse in cycles.
REQ-003 SHALL have parameter STALL_CYCLES, default 1024, the number of cycles without a JSELECT edge before a stall is flagged.
REQ-004 CLK  input  1  single clock; all state on rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 P1_RAW  input  8  player-1 edge-connector lines, active-low, asynchronous; [5:0] directions/fire, [7] start.
REQ-007 P2_RAW  input  8  player-2 lines, same encoding as P1_RAW.
REQ-008 COIN_RAW  input  2  coin switches, active-low, asynchronous.
REQ-009 JSELECT  input  1  player select from the sampling board: 0 = player 1, 1 = player 2.
REQ-010 JJOY  output  8  multiplexed active-low player vector.
REQ-011 JCOIN  output  2  conditioned coin lines, active-low.
REQ-012 SEL_STALL  output  1  high while JSELECT has stopped toggling.

Function
REQ-013 Each bit of P1_RAW, P2_RAW and COIN_RAW SHALL pass through a 2-flop synchronizer; the flops reset to 1.
REQ-014 Debounce SHALL be per bit: a counter increments while the synchronized bit differs from the clean bit and clears when they are equal.
REQ-015 The clean bit SHALL take the synchronized value in the cycle the counter reaches DEB_CYCLES-1, and the counter SHALL clear in that same cycle.
REQ-016 JJOY SHALL be P2 clean when JSELECT=1 and P1 clean when JSELECT=0, combinationally from registered clean vectors, with zero-cycle select latency so the sampler can toggle JSELECT every cycle.
REQ-017 Coin FSM per bit, states IDLE, HOLD, WAIT_REL:
- IDLE: on a clean-coin falling edge, go to HOLD, load the counter with COIN_MIN-1 and drive JCOIN low.
- HOLD: decrement; at 0, go to WAIT_REL.
- WAIT_REL: keep JCOIN low until the clean coin is high, then go to IDLE and drive JCOIN high.
REQ-018 A new coin edge during HOLD or WAIT_REL SHALL be ignored; no retrigger and no extension.
REQ-019 The stall counter SHALL clear on every JSELECT change (previous-value register) and otherwise saturate at STALL_CYCLES.
REQ-020 SEL_STALL SHALL be 1 while the stall counter equals STALL_CYCLES and SHALL drop the cycle after the next JSELECT change.
REQ-021 Counter widths SHALL be $clog2(param+1); counters SHALL never wrap.

Reset
REQ-022 On RESET: clean vectors = 8'hFF, synchronizers = 1, debounce counters = 0, coin FSMs = IDLE, JCOIN = 2'b11, stall counter = 0, SEL_STALL = 0, previous-JSELECT register = 0.
REQ-023 RESET asserted mid-debounce or mid-coin pulse SHALL abort the operation; JCOIN SHALL be high the cycle after RESET is sampled.

Configuration
REQ-024 With macro JAMMA_JOY_DEBOUNCE_EN defined, the debounce of REQ-014/015 SHALL be compiled in.
REQ-025 Without JAMMA_JOY_DEBOUNCE_EN, the clean bits SHALL equal the synchronizer outputs registered once, giving 3-cycle input latency, and no debounce counters SHALL exist.
REQ-026 COIN_MIN stretching and SEL_STALL SHALL be present in both builds.

Structure
REQ-027 A shared package jamma_pkg SHALL hold the bit-index constants (UP, DOWN, LEFT, RIGHT, FIRE1, FIRE2, START) and the coin FSM state typedef.
REQ-028 Debounce SHALL be one sub-module, jamma_debounce (1-bit, DEB_CYCLES parameter), instantiated 18 times.

Verification
REQ-029 Toggle JSELECT every cycle with P1_RAW=8'hFE and P2_RAW=8'h7F, held stable for more than DEB_CYCLES+3 cycles -> JJOY alternates 8'hFE/8'h7F in the same cycle as JSELECT.
REQ-030 Glitch P1_RAW[4] low for 10 cycles with DEB_CYCLES=16 -> JJOY[4] stays 1; hold it low 20 cycles -> JJOY[4]=0 exactly 2+16 cycles after the first low sample.
REQ-031 Pulse COIN_RAW[0] low for 40 cycles with COIN_MIN=4096 -> JCOIN[0] is low for exactly 4096 cycles; a second press during HOLD produces no extension.
REQ-032 Hold COIN_RAW[1] low for 5000 cycles -> JCOIN[1] stays low until the clean release, then goes high in one cycle.
REQ-033 Freeze JSELECT for 1024 cycles -> SEL_STALL=1; one JSELECT toggle -> SEL_STALL=0 the next cycle.
REQ-034 Assert RESET during HOLD and mid-debounce -> JCOIN=2'b11, JJOY=8'hFF and SEL_STALL=0 one cycle later; repeat the REQ-030 timing in a build without JAMMA_JOY_DEBOUNCE_EN -> 3-cycle latency.
